// File: rtl/udc_pkg.sv
// udc_pkg: direction encoding and terminal-count helper for up_down_counter_n
package udc_pkg;
  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;
  function automatic logic [31:0] tc_value(input int unsigned n, input dir_e dir);
    return (dir == DIR_UP) ? (32'hFFFF_FFFF >> (32 - n)) : 32'd0;
  endfunction
endpackage

// File: rtl/up_down_counter_n_if.sv
// up_down_counter_n_if: control/data bundle between a counter stage and its driver
interface up_down_counter_n_if #(parameter int N = 4);
  logic en_b;
  logic load_b;
  logic up;
  logic [N-1:0] load_in;
  logic [N-1:0] q;
  logic rco_b;
  modport master (output en_b, load_b, up, load_in, input q, rco_b);
  modport slave (input en_b, load_b, up, load_in, output q, rco_b);
endinterface

// File: rtl/udc_tc_detect.sv
// udc_tc_detect: combinational terminal-count decode driving active-low ripple carry
module udc_tc_detect
  import udc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] q,
  input  logic         up,
  input  logic         en_b,
  output logic         rco_b
);
  logic at_tc;
  // carry is asserted only while enabled and sitting on the terminal value for this direction
  always_comb begin
    at_tc = q == N'(tc_value(N, dir_e'(up)));
    rco_b = ~(~en_b & at_tc);
  end
endmodule

// File: rtl/up_down_counter_n.sv
// up_down_counter_n: 74x169-style up/down counter with load and ripple carry; UP_DOWN_COUNTER_SAT_EN selects saturating mode
module up_down_counter_n
  import udc_pkg::*;
#(
  parameter int N = 4
) (
  input logic clk,
  input logic rst,
  up_down_counter_n_if.slave bus
);
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] stepped;
  logic hold_tc;
`ifdef UP_DOWN_COUNTER_SAT_EN
  assign hold_tc = q_q == N'(tc_value(N, dir_e'(bus.up)));
`else
  assign hold_tc = 1'b0;
`endif
  // next state: load beats count beats hold
  always_comb begin
    stepped = bus.up ? q_q + N'(1) : q_q - N'(1);
    q_d = !bus.load_b ? bus.load_in : (!bus.en_b && !hold_tc) ? stepped : q_q;
  end
  // counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else q_q <= q_d;
  end
  assign bus.q = q_q;
  udc_tc_detect #(.N(N)) u_tc (
    .q(q_q),
    .up(bus.up),
    .en_b(bus.en_b),
    .rco_b(bus.rco_b)
  );
endmodule

// File: tb/tb_up_down_counter_n.sv
// tb_up_down_counter_n: scoreboard bench driving N=4 and N=5 counters with directed vectors
module tb_up_down_counter_n;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  up_down_counter_n_if #(.N(4)) b4 ();
  up_down_counter_n_if #(.N(5)) b5 ();
  up_down_counter_n #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  up_down_counter_n #(.N(5)) dut5 (.clk(clk), .rst(rst), .bus(b5));
  typedef struct {
    logic [3:0] q4;
    logic r4;
    logic [4:0] q5;
    logic r5;
    string tag;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int fails = 0;
  int m4 = 0;
  int m5 = 0;
  function automatic int nxt(int m, int md, logic r, logic e, logic l, logic u, int lin);
    if (r) return 0;
    if (!l) return lin;
    if (e) return m;
`ifdef UP_DOWN_COUNTER_SAT_EN
    if (u && m == md - 1) return m;
    if (!u && m == 0) return m;
`endif
    return u ? (m + 1) % md : (m + md - 1) % md;
  endfunction
  function automatic logic rco(int m, int md, logic e, logic u);
    return !(!e && ((u && m == md - 1) || (!u && m == 0)));
  endfunction
  task automatic step(input logic r, input logic e, input logic l, input logic u, input int l4, input int l5, input string tag);
    exp_t x;
    @(negedge clk);
    rst = r;
    b4.en_b = e; b4.load_b = l; b4.up = u; b4.load_in = 4'(l4);
    b5.en_b = e; b5.load_b = l; b5.up = u; b5.load_in = 5'(l5);
    m4 = nxt(m4, 16, r, e, l, u, l4);
    m5 = nxt(m5, 32, r, e, l, u, l5);
    x.q4 = 4'(m4); x.r4 = rco(m4, 16, e, u);
    x.q5 = 5'(m5); x.r5 = rco(m5, 32, e, u);
    x.tag = tag;
    sb.push_back(x);
  endtask
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      checks += 4;
      if (b4.q !== x.q4) begin fails++; $display("FAIL %s q4: got %0d want %0d", x.tag, b4.q, x.q4); end
      if (b4.rco_b !== x.r4) begin fails++; $display("FAIL %s rco4: got %b want %b", x.tag, b4.rco_b, x.r4); end
      if (b5.q !== x.q5) begin fails++; $display("FAIL %s q5: got %0d want %0d", x.tag, b5.q, x.q5); end
      if (b5.rco_b !== x.r5) begin fails++; $display("FAIL %s rco5: got %b want %b", x.tag, b5.rco_b, x.r5); end
    end
  end
  initial begin
    b4.en_b = 1'b1; b4.load_b = 1'b1; b4.up = 1'b1; b4.load_in = '0;
    b5.en_b = 1'b1; b5.load_b = 1'b1; b5.up = 1'b1; b5.load_in = '0;
    step(1, 0, 1, 0, 0, 0, "reset_rco_low");
    step(1, 1, 1, 0, 0, 0, "reset_rco_high");
    step(0, 0, 0, 1, 0, 0, "load_zero");
    for (int i = 0; i < 34; i++) step(0, 0, 1, 1, 0, 0, "count_up");
    step(0, 0, 0, 0, 15, 31, "load_top");
    for (int i = 0; i < 34; i++) step(0, 0, 1, 0, 0, 0, "count_down");
    step(0, 0, 0, 1, 10, 10, "load_priority");
    step(0, 1, 0, 1, 5, 21, "load_disabled");
    step(0, 1, 1, 1, 0, 0, "hold_up");
    step(0, 1, 1, 0, 0, 0, "hold_down");
    step(0, 0, 0, 1, 15, 31, "load_tc");
    step(0, 1, 1, 1, 0, 0, "hold_at_tc");
    step(0, 0, 1, 0, 0, 0, "dir_change_down");
    step(0, 0, 1, 1, 0, 0, "dir_change_up");
    step(0, 0, 1, 1, 0, 0, "dir_change_up2");
    step(1, 0, 0, 1, 15, 31, "reset_over_load");
    step(0, 1, 1, 0, 0, 0, "post_reset_hold");
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin fails++; $display("FAIL drain: got %0d pending want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
